// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: buffers ALU and load write-backs in per-requester FIFOs and
// drains one entry per cycle, round-robin, into a registered register-file write port.
module wb_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    // ALU requester
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    // Load requester
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    // Register-file write port
    output logic              write_back_en,
    output logic [ADDR_W-1:0] write_back_addr,
    output logic [DATA_W-1:0] write_back_data,
    output logic [7:0]        conflict_count
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef enum logic {
        GrantAlu,
        GrantMem
    } grant_e;

    // ------------------------------------------------------------------
    // ALU FIFO
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] alu_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] alu_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  alu_wptr_q, alu_wptr_d;
    logic [PTR_W-1:0]  alu_rptr_q, alu_rptr_d;
    logic              alu_full, alu_empty, alu_push, alu_pop;
    logic [ADDR_W-1:0] alu_head_addr;
    logic [DATA_W-1:0] alu_head_data;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign alu_full  = (alu_wptr_q[PTR_W-1] != alu_rptr_q[PTR_W-1]) &&
                       (alu_wptr_q[IDX_W-1:0] == alu_rptr_q[IDX_W-1:0]);
    assign alu_empty = (alu_wptr_q == alu_rptr_q);
    assign alu_ready = !alu_full;
    assign alu_push  = alu_valid && !alu_full;

    assign alu_head_addr = alu_addr_mem[alu_rptr_q[IDX_W-1:0]];
    assign alu_head_data = alu_data_mem[alu_rptr_q[IDX_W-1:0]];

    always_comb begin
        alu_wptr_d = alu_wptr_q;
        alu_rptr_d = alu_rptr_q;
        if (alu_push) begin
            alu_wptr_d = alu_wptr_q + PTR_W'(1);
        end
        if (alu_pop) begin
            alu_rptr_d = alu_rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_addr_mem[alu_wptr_q[IDX_W-1:0]] <= alu_addr;
            alu_data_mem[alu_wptr_q[IDX_W-1:0]] <= alu_data;
        end
    end

    // ------------------------------------------------------------------
    // Load FIFO
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] mem_addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  mem_wptr_q, mem_wptr_d;
    logic [PTR_W-1:0]  mem_rptr_q, mem_rptr_d;
    logic              mem_full, mem_empty, mem_push, mem_pop;
    logic [ADDR_W-1:0] mem_head_addr;
    logic [DATA_W-1:0] mem_head_data;

    assign mem_full  = (mem_wptr_q[PTR_W-1] != mem_rptr_q[PTR_W-1]) &&
                       (mem_wptr_q[IDX_W-1:0] == mem_rptr_q[IDX_W-1:0]);
    assign mem_empty = (mem_wptr_q == mem_rptr_q);
    assign mem_ready = !mem_full;
    assign mem_push  = mem_valid && !mem_full;

    assign mem_head_addr = mem_addr_mem[mem_rptr_q[IDX_W-1:0]];
    assign mem_head_data = mem_data_mem[mem_rptr_q[IDX_W-1:0]];

    always_comb begin
        mem_wptr_d = mem_wptr_q;
        mem_rptr_d = mem_rptr_q;
        if (mem_push) begin
            mem_wptr_d = mem_wptr_q + PTR_W'(1);
        end
        if (mem_pop) begin
            mem_rptr_d = mem_rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_push) begin
            mem_addr_mem[mem_wptr_q[IDX_W-1:0]] <= mem_addr;
            mem_data_mem[mem_wptr_q[IDX_W-1:0]] <= mem_data;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin scheduler and registered write port
    // ------------------------------------------------------------------
    grant_e            last_grant_q, last_grant_d;
    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [7:0]        conflict_q, conflict_d;

    always_comb begin
        last_grant_d = last_grant_q;
        conflict_d   = conflict_q;
        alu_pop      = 1'b0;
        mem_pop      = 1'b0;
        wb_en_d      = 1'b0;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;

        if (!alu_empty && !mem_empty) begin
            if (conflict_q != 8'hFF) begin
                conflict_d = conflict_q + 8'd1;
            end
            if (last_grant_q == GrantMem) begin
                alu_pop = 1'b1;
            end else begin
                mem_pop = 1'b1;
            end
        end else if (!alu_empty) begin
            alu_pop = 1'b1;
        end else if (!mem_empty) begin
            mem_pop = 1'b1;
        end

        if (alu_pop) begin
            wb_en_d      = 1'b1;
            wb_addr_d    = alu_head_addr;
            wb_data_d    = alu_head_data;
            last_grant_d = GrantAlu;
        end else if (mem_pop) begin
            wb_en_d      = 1'b1;
            wb_addr_d    = mem_head_addr;
            wb_data_d    = mem_head_data;
            last_grant_d = GrantMem;
        end
    end

    // Reset starts with last_grant = MEM so the first contended cycle favours the ALU.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_wptr_q   <= '0;
            alu_rptr_q   <= '0;
            mem_wptr_q   <= '0;
            mem_rptr_q   <= '0;
            last_grant_q <= GrantMem;
            wb_en_q      <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            conflict_q   <= '0;
        end else begin
            alu_wptr_q   <= alu_wptr_d;
            alu_rptr_q   <= alu_rptr_d;
            mem_wptr_q   <= mem_wptr_d;
            mem_rptr_q   <= mem_rptr_d;
            last_grant_q <= last_grant_d;
            wb_en_q      <= wb_en_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            conflict_q   <= conflict_d;
        end
    end

    assign write_back_en   = wb_en_q;
    assign write_back_addr = wb_addr_q;
    assign write_back_data = wb_data_q;
    assign conflict_count  = conflict_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter: reset, single write, contention,
// streaming alternation, FIFO-full refusal, counter saturation and mid-operation reset.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        write_back_en;
    logic [3:0]  write_back_addr;
    logic [31:0] write_back_data;
    logic [7:0]  conflict_count;

    int errors;
    int checks;

    wb_port_arbiter #(
        .DATA_W    (32),
        .ADDR_W    (4),
        .FIFO_DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_valid      (alu_valid),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .alu_ready      (alu_ready),
        .mem_valid      (mem_valid),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_ready      (mem_ready),
        .write_back_en  (write_back_en),
        .write_back_addr(write_back_addr),
        .write_back_data(write_back_data),
        .conflict_count (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (write_back_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_en: got %0b expected 0", write_back_en);
        end
        checks++;
        if (write_back_addr !== 4'd0 || write_back_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_addr_data: got %0h/%0h expected 0/0", write_back_addr,
                     write_back_data);
        end
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got alu=%0b mem=%0b expected 1/1", alu_ready, mem_ready);
        end
        checks++;
        if (conflict_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", conflict_count);
        end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1;
        alu_addr  = 4'd3;
        alu_data  = 32'h1234_5678;
        tick();
        idle_inputs();
        checks++;
        if (write_back_en !== 1'b0) begin
            errors++;
            $display("FAIL single_push_cycle_en: got %0b expected 0", write_back_en);
        end
        tick();
        checks++;
        if (write_back_en !== 1'b1 || write_back_addr !== 4'd3 ||
            write_back_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL single_write: got en=%0b addr=%0d data=%0h expected 1/3/12345678",
                     write_back_en, write_back_addr, write_back_data);
        end
        tick();
        checks++;
        if (write_back_en !== 1'b0 || write_back_addr !== 4'd3 ||
            write_back_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL single_hold: got en=%0b addr=%0d data=%0h expected 0/3/12345678",
                     write_back_en, write_back_addr, write_back_data);
        end
    endtask

    task automatic test_contention();
        do_reset();
        alu_valid = 1'b1;
        alu_addr  = 4'd5;
        alu_data  = 32'hA;
        mem_valid = 1'b1;
        mem_addr  = 4'd6;
        mem_data  = 32'hB;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (write_back_en !== 1'b1 || write_back_addr !== 4'd5 || write_back_data !== 32'hA) begin
            errors++;
            $display("FAIL contend_first_alu: got en=%0b addr=%0d data=%0h expected 1/5/a",
                     write_back_en, write_back_addr, write_back_data);
        end
        tick();
        checks++;
        if (write_back_en !== 1'b1 || write_back_addr !== 4'd6 || write_back_data !== 32'hB) begin
            errors++;
            $display("FAIL contend_second_mem: got en=%0b addr=%0d data=%0h expected 1/6/b",
                     write_back_en, write_back_addr, write_back_data);
        end
        tick();
        checks++;
        if (write_back_en !== 1'b0 || conflict_count !== 8'd1) begin
            errors++;
            $display("FAIL contend_end: got en=%0b count=%0d expected 0/1", write_back_en,
                     conflict_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] aq[$];
        logic [31:0] mq[$];
        logic        expect_alu;
        int          writes;
        int          acc_alu;
        int          acc_mem;
        do_reset();
        expect_alu = 1'b1;
        writes     = 0;
        acc_alu    = 0;
        acc_mem    = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) begin
                tick();
                checks++;
                if (alu_ready === 1'b0 && mem_ready === 1'b0) begin
                    errors++;
                    $display("FAIL stream_ready: cycle %0d got both low expected one high", cyc);
                end
                if (write_back_en === 1'b1) begin
                    checks++;
                    if (expect_alu) begin
                        if (aq.size() == 0 || write_back_data !== aq[0]) begin
                            errors++;
                            $display("FAIL stream_alu_write: cycle %0d got %0h expected ALU head",
                                     cyc, write_back_data);
                        end
                        if (aq.size() != 0) void'(aq.pop_front());
                    end else begin
                        if (mq.size() == 0 || write_back_data !== mq[0]) begin
                            errors++;
                            $display("FAIL stream_mem_write: cycle %0d got %0h expected MEM head",
                                     cyc, write_back_data);
                        end
                        if (mq.size() != 0) void'(mq.pop_front());
                    end
                    expect_alu = !expect_alu;
                    writes++;
                end
            end
            if (cyc < 10) begin
                alu_valid = 1'b1;
                alu_addr  = 4'(cyc);
                alu_data  = 32'hA000_0000 | 32'(cyc);
                mem_valid = 1'b1;
                mem_addr  = 4'(cyc + 8);
                mem_data  = 32'hB000_0000 | 32'(cyc);
                if (alu_ready === 1'b1) begin
                    aq.push_back(alu_data);
                    acc_alu++;
                end
                if (mem_ready === 1'b1) begin
                    mq.push_back(mem_data);
                    acc_mem++;
                end
            end else begin
                idle_inputs();
            end
        end
        checks++;
        if (acc_alu != 6 || acc_mem != 6) begin
            errors++;
            $display("FAIL stream_accepted: got alu=%0d mem=%0d expected 6/6", acc_alu, acc_mem);
        end
        checks++;
        if (writes != 12 || aq.size() != 0 || mq.size() != 0) begin
            errors++;
            $display("FAIL stream_drained: got writes=%0d left=%0d/%0d expected 12 0/0", writes,
                     aq.size(), mq.size());
        end
    endtask

    task automatic test_fill();
        logic        av  [7];
        logic [3:0]  aa  [7];
        logic [31:0] ad  [7];
        logic        mv  [7];
        logic [3:0]  ma  [7];
        logic [31:0] md  [7];
        logic        xen [7];
        logic [3:0]  xad [7];
        logic [31:0] xdt [7];
        av  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        aa  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0};
        ad  = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 32'h0, 32'h0};
        mv  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        ma  = '{4'd8, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        md  = '{32'h81, 32'h92, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        xen = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        xad = '{4'd0, 4'd1, 4'd8, 4'd2, 4'd9, 4'd3, 4'd3};
        xdt = '{32'h0, 32'h11, 32'h81, 32'h22, 32'h92, 32'h33, 32'h33};
        do_reset();
        for (int e = 0; e < 7; e++) begin
            alu_valid = av[e];
            alu_addr  = aa[e];
            alu_data  = ad[e];
            mem_valid = mv[e];
            mem_addr  = ma[e];
            mem_data  = md[e];
            tick();
            checks++;
            if (write_back_en !== xen[e] || write_back_addr !== xad[e] ||
                write_back_data !== xdt[e]) begin
                errors++;
                $display("FAIL fill_write: edge %0d got %0b/%0d/%0h expected %0b/%0d/%0h", e + 1,
                         write_back_en, write_back_addr, write_back_data, xen[e], xad[e], xdt[e]);
            end
            if (e == 2) begin
                checks++;
                if (alu_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_full_ready: got %0b expected 0", alu_ready);
                end
            end
        end
        checks++;
        if (conflict_count !== 8'd4) begin
            errors++;
            $display("FAIL fill_count: got %0d expected 4", conflict_count);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 1; n <= 300; n++) begin
            alu_valid = 1'b1;
            alu_addr  = 4'(n);
            alu_data  = 32'(n);
            mem_valid = 1'b1;
            mem_addr  = 4'(n + 1);
            mem_data  = 32'(n) | 32'h8000_0000;
            tick();
            if (n == 101 || n == 255) begin
                checks++;
                if (conflict_count !== 8'(n - 1)) begin
                    errors++;
                    $display("FAIL sat_count_ramp: edge %0d got %0d expected %0d", n,
                             conflict_count, n - 1);
                end
            end
            if (n == 256 || n == 300) begin
                checks++;
                if (conflict_count !== 8'd255) begin
                    errors++;
                    $display("FAIL sat_count_hold: edge %0d got %0d expected 255", n,
                             conflict_count);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (write_back_en !== 1'b0 || write_back_addr !== 4'd0 || write_back_data !== 32'd0) begin
            errors++;
            $display("FAIL midrst_port: got en=%0b addr=%0d data=%0h expected 0/0/0",
                     write_back_en, write_back_addr, write_back_data);
        end
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1 || conflict_count !== 8'd0) begin
            errors++;
            $display("FAIL midrst_state: got ready=%0b/%0b count=%0d expected 1/1 0", alu_ready,
                     mem_ready, conflict_count);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (write_back_en !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale: cycle %0d got en=%0b expected 0", i, write_back_en);
            end
        end
        alu_valid = 1'b1;
        alu_addr  = 4'd7;
        alu_data  = 32'h77;
        tick();
        idle_inputs();
        tick();
        checks++;
        if (write_back_en !== 1'b1 || write_back_addr !== 4'd7 || write_back_data !== 32'h77) begin
            errors++;
            $display("FAIL midrst_fresh: got en=%0b addr=%0d data=%0h expected 1/7/77",
                     write_back_en, write_back_addr, write_back_data);
        end
        tick();
        checks++;
        if (write_back_en !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: got en=%0b expected 0", write_back_en);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_single_alu();
        test_contention();
        test_back_to_back();
        test_fill();
        test_saturation();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
